// File: rtl/ch1_sweep_ctrl.sv
// Channel 1 frequency-sweep sequencer: NR10/NR14 decode, sweep frame
// counter and the LOAD/SHIFT/CHECK/UPDATE control FSM for the datapath.
module ch1_sweep_ctrl (
    input  logic       apu_clk,
    input  logic       apu_reset,
    input  logic [7:0] d,
    input  logic       apu_wr,
    input  logic       ff10,
    input  logic       ff14,
    input  logic       tick_128hz,
    input  logic       sum_ovf,
    output logic       ch1_ld_shift,
    output logic       ch1_shift_clk,
    output logic       ch1_freq_upd,
    output logic       nff10_d3,
    output logic       ch1_sweep_off,
    output logic       sweep_busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        CHECK,
        UPDATE,
        RECHK_LOAD,
        RECHK_SHIFT,
        RECHK_CHECK
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [2:0] period;
    logic       negate;
    logic [2:0] shift;
    logic [3:0] pcnt;
    logic [2:0] step;
    logic       sweep_en;
    logic       neg_used;
    logic       pending;
    logic       is_upd;

    logic       trig;
    logic       nr10_wr;
    logic       tick_go;
    logic       cnt_wrap;
    logic       calc_req;
    logic       start;
    logic       chk;
    logic       ovf_fail;
    logic [3:0] reload;

    assign trig     = apu_wr & ff14 & d[7];
    assign nr10_wr  = apu_wr & ff10;
    assign tick_go  = tick_128hz & sweep_en & ~trig;
    assign cnt_wrap = (pcnt <= 4'd1);
    assign calc_req = tick_go & cnt_wrap & (period != 3'd0);
    assign start    = (state == IDLE) & (pending | calc_req);
    assign chk      = (state == CHECK) | (state == RECHK_CHECK);
    assign ovf_fail = chk & ~negate & sum_ovf;
    assign reload   = (period == 3'd0) ? 4'd8 : {1'b0, period};

    assign nff10_d3   = ~negate;
    assign sweep_busy = (state != IDLE);

    always_comb begin
        state_n       = state;
        ch1_ld_shift  = 1'b0;
        ch1_shift_clk = 1'b0;
        ch1_freq_upd  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start)
                    state_n = LOAD;
            end
            LOAD: begin
                ch1_ld_shift = 1'b1;
                state_n = (shift != 3'd0) ? SHIFT : CHECK;
            end
            SHIFT: begin
                ch1_shift_clk = 1'b1;
                if (step == 3'd1)
                    state_n = CHECK;
            end
            CHECK: begin
                if (ovf_fail)
                    state_n = IDLE;
                else if (is_upd && shift != 3'd0)
                    state_n = UPDATE;
                else
                    state_n = IDLE;
            end
            UPDATE: begin
                ch1_freq_upd = 1'b1;
                state_n = RECHK_LOAD;
            end
            RECHK_LOAD: begin
                ch1_ld_shift = 1'b1;
                state_n = (shift != 3'd0) ? RECHK_SHIFT : RECHK_CHECK;
            end
            RECHK_SHIFT: begin
                ch1_shift_clk = 1'b1;
                if (step == 3'd1)
                    state_n = RECHK_CHECK;
            end
            RECHK_CHECK: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // a trigger always restarts from scratch
        if (trig)
            state_n = (shift != 3'd0) ? LOAD : IDLE;
    end

    always_ff @(posedge apu_clk or posedge apu_reset) begin
        if (apu_reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge apu_clk or posedge apu_reset) begin
        if (apu_reset) begin
            period <= 3'd0;
            negate <= 1'b0;
            shift  <= 3'd0;
        end else if (nr10_wr) begin
            period <= d[6:4];
            negate <= d[3];
            shift  <= d[2:0];
        end
    end

    always_ff @(posedge apu_clk or posedge apu_reset) begin
        if (apu_reset) begin
            pcnt     <= 4'd0;
            sweep_en <= 1'b0;
        end else if (trig) begin
            pcnt     <= reload;
            sweep_en <= (period != 3'd0) || (shift != 3'd0);
        end else if (tick_go) begin
            pcnt <= cnt_wrap ? reload : pcnt - 4'd1;
        end
    end

    always_ff @(posedge apu_clk or posedge apu_reset) begin
        if (apu_reset)
            step <= 3'd0;
        else if (state == LOAD || state == RECHK_LOAD)
            step <= shift;
        else if (state == SHIFT || state == RECHK_SHIFT)
            step <= step - 3'd1;
    end

    // one request may wait while a sequence is still running
    always_ff @(posedge apu_clk or posedge apu_reset) begin
        if (apu_reset) begin
            pending <= 1'b0;
            is_upd  <= 1'b0;
        end else if (trig) begin
            pending <= 1'b0;
            is_upd  <= 1'b0;
        end else if (start) begin
            pending <= pending & calc_req;
            is_upd  <= 1'b1;
        end else begin
            pending <= pending | calc_req;
        end
    end

    always_ff @(posedge apu_clk or posedge apu_reset) begin
        if (apu_reset) begin
            neg_used      <= 1'b0;
            ch1_sweep_off <= 1'b0;
        end else if (trig) begin
            neg_used      <= 1'b0;
            ch1_sweep_off <= 1'b0;
        end else begin
            if (chk && negate)
                neg_used <= 1'b1;
            if (ovf_fail || (nr10_wr && !d[3] && neg_used))
                ch1_sweep_off <= 1'b1;
        end
    end

endmodule
